rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised reorder buffer, successor to the fixed-size ROB: configurable depth/width, occupancy count, two writeback channels, same-cycle operand bypass.
- Flushes only on branch misprediction, checked against a prediction bit stored at dispatch, instead of on every taken branch or jump.
- Sits between Dispatch (allocation, operand lookup), ALU/LSB (writeback), and Regfile/LSB/IF (in-order commit, store release, redirect).

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2.
- IDX_W, 4, tag width; equals log2(DEPTH).
- DATA_W, 32, result value width.
- ADDR_W, 32, pc/target width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when low, state holds and all commit pulses are 0
- disp_valid  in  1  allocate an entry this cycle
- disp_kind  in  2  entry kind: 0 REG, 1 BRANCH, 2 STORE, 3 JUMP
- disp_rd  in  REG_W  destination register
- disp_pc  in  ADDR_W  instruction pc
- disp_pred_taken  in  1  front-end prediction
- alloc_tag  out  IDX_W  tag the next dispatch receives (equals tail)
- full  out  1  count==DEPTH
- count  out  IDX_W+1  occupied entries
- q1_tag / q2_tag  in  IDX_W  operand lookup tags
- q1_ready / q2_ready  out  1  value available
- q1_value / q2_value  out  DATA_W  value
- wb0_valid / wb1_valid  in  1  writeback from ALU (0) and LSB (1)
- wb0_tag / wb1_tag  in  IDX_W  target entry
- wb0_value / wb1_value  in  DATA_W  result
- wb0_taken  in  1  actual branch outcome (ALU only)
- wb0_target  in  ADDR_W  actual taken target (ALU only)
- commit_reg_valid  out  1  regfile write pulse
- commit_rd  out  REG_W  destination register
- commit_tag  out  IDX_W  tag of the committed entry
- commit_value  out  DATA_W  committed value
- commit_store_valid  out  1  store release pulse to LSB
- redirect_valid  out  1  pc redirect pulse to IF
- redirect_pc  out  ADDR_W  redirect address
- flush  out  1  pipeline clear pulse

Behaviour:
- Reset (async): head=tail=count=0; all ready bits=0; every registered output=0.
- Entry fields: kind, rd, pc, pred_taken, value, taken, target, ready.
- Dispatch is accepted iff disp_valid && !full && !flush && rdy.
  - Writes the entry at tail; tail wraps modulo DEPTH.
  - STORE entries are ready at allocation. All other kinds are not ready, and their taken, target and value fields are cleared.
  - disp_valid while full is ignored; no state changes.
- Writeback: each channel sets ready and value on its entry; wb0 also latches taken and target.
  - Both channels may be valid in the same cycle on different tags; on equal tags, wb1 wins.
- Operand lookup (combinational), priority order:
  - tag matches a valid wb1: return wb1 data, ready=1;
  - else tag matches a valid wb0: return wb0 data, ready=1;
  - else return the stored ready bit and value.
- Commit: at most one per cycle, when count>0 and ready[head]. Outputs are registered and pulse for 1 cycle; head advances.
  - REG: commit_reg_valid=1 with rd, tag, value.
  - STORE: commit_store_valid=1 and commit_tag=head.
  - JUMP: as REG, plus the misprediction check using taken=1.
  - BRANCH: no register write; misprediction check only.
- Misprediction means taken != pred_taken.
  - On a misprediction: redirect_valid=1 and flush=1 in the same cycle.
  - redirect_pc = taken ? target : pc+4 (ADDR_W wrap).
- Flush cycle (flush==1 at the clock edge):
  - head=tail=count=0 and all ready bits cleared.
  - Dispatch and writeback in that cycle are ignored.
  - All commit outputs return to 0.
- count update: count_next = count + accept - commit, so simultaneous dispatch and commit leave count unchanged. Dispatch while full is not accepted, even if a commit happens the same cycle.
- rdy low: no state change; pulse outputs are forced to 0.
- rst asserted mid-operation: immediate return to reset state; no pulse may extend past the reset edge.

Test Plan:
- After reset, dispatch 16 REG entries (DEPTH=16), with no writeback -> full=1 and count=16; a 17th disp_valid is ignored and alloc_tag stays 0.
- Writebacks out of order, then commit: dispatch tags 0,1,2 (rd=5,6,7); wb0 tag2=0x30, wb1 tag0=0x10, wb0 tag1=0x20 -> commits occur in order 0,1,2 with commit_value 0x10,0x20,0x30 and commit_rd 5,6,7.
- Same-cycle bypass: q1_tag=3 while wb1_valid with tag 3 and value 0xABCD -> q1_ready=1 and q1_value=0xABCD in that same cycle.
- Correct prediction, no flush: BRANCH at pc 0x100 with pred_taken=1, wb0_taken=1 -> commit with redirect_valid=0, flush=0, and count decrements.
- Misprediction flush: BRANCH at pc 0x200 with pred_taken=1, wb0_taken=0 -> redirect_valid=1, redirect_pc=0x204, flush=1; on the next cycle count=0 and alloc_tag=0, and a writeback arriving during the flush is ignored.
- Wrap and simultaneous events:
  - Fill and drain across the index wrap 15->0 with dispatch and commit in the same cycle -> count stays constant and tags wrap correctly.
  - Assert rst while commit pulses are active -> all outputs are 0 immediately.

Source files
------------

// File: rtl/rob_if.sv
// Reorder buffer bus: dispatch, operand lookup,
// writeback and commit signal groups.
interface rob_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
);
  logic              disp_valid;
  logic [1:0]        disp_kind;
  logic [REG_W-1:0]  disp_rd;
  logic [ADDR_W-1:0] disp_pc;
  logic              disp_pred_taken;
  logic [IDX_W-1:0]  alloc_tag;
  logic              full;
  logic [IDX_W:0]    count;

  logic [IDX_W-1:0]  q1_tag;
  logic [IDX_W-1:0]  q2_tag;
  logic              q1_ready;
  logic              q2_ready;
  logic [DATA_W-1:0] q1_value;
  logic [DATA_W-1:0] q2_value;

  logic              wb0_valid;
  logic [IDX_W-1:0]  wb0_tag;
  logic [DATA_W-1:0] wb0_value;
  logic              wb0_taken;
  logic [ADDR_W-1:0] wb0_target;
  logic              wb1_valid;
  logic [IDX_W-1:0]  wb1_tag;
  logic [DATA_W-1:0] wb1_value;

  logic              commit_reg_valid;
  logic [REG_W-1:0]  commit_rd;
  logic [IDX_W-1:0]  commit_tag;
  logic [DATA_W-1:0] commit_value;
  logic              commit_store_valid;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;

  modport master (
    output disp_valid, disp_kind, disp_rd,
    output disp_pc, disp_pred_taken,
    output q1_tag, q2_tag,
    output wb0_valid, wb0_tag, wb0_value,
    output wb0_taken, wb0_target,
    output wb1_valid, wb1_tag, wb1_value,
    input  alloc_tag, full, count,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  commit_reg_valid, commit_rd,
    input  commit_tag, commit_value,
    input  commit_store_valid,
    input  redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  disp_valid, disp_kind, disp_rd,
    input  disp_pc, disp_pred_taken,
    input  q1_tag, q2_tag,
    input  wb0_valid, wb0_tag, wb0_value,
    input  wb0_taken, wb0_target,
    input  wb1_valid, wb1_tag, wb1_value,
    output alloc_tag, full, count,
    output q1_ready, q2_ready, q1_value, q2_value,
    output commit_reg_valid, commit_rd,
    output commit_tag, commit_value,
    output commit_store_valid,
    output redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order commit, two
// writeback ports, operand bypass, mispredict flush.
module rob_param #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  rob_if.slave io
);
  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_JMP = 2'd3;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0]  head, tail;
  logic [IDX_W:0]    cnt;
  logic [DEPTH-1:0]  ready_q;
  logic [DEPTH-1:0]  pred_q;
  logic [DEPTH-1:0]  tkn_q;
  logic [1:0]        kind_q [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] tgt_q  [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];

  logic              c_reg, c_store, c_redir, c_flush;
  logic [REG_W-1:0]  c_rd;
  logic [IDX_W-1:0]  c_tag;
  logic [DATA_W-1:0] c_val;
  logic [ADDR_W-1:0] c_pc;

  logic full, live, accept, do_commit, wb0_ok, wb1_ok;
  logic is_reg, is_st, is_chk, eff_taken, mispred;
  logic [ADDR_W-1:0] redir_pc;

  assign full      = cnt == DEPTH_C;
  assign live      = rdy && !c_flush;
  assign accept    = live && io.disp_valid && !full;
  assign wb0_ok    = live && io.wb0_valid;
  assign wb1_ok    = live && io.wb1_valid;
  assign do_commit = live && cnt != '0 && ready_q[head];

  always_comb begin
    is_reg    = 1'b0;
    is_st     = 1'b0;
    is_chk    = 1'b0;
    eff_taken = tkn_q[head];
    unique case (1'b1)
      kind_q[head] == K_REG: is_reg = 1'b1;
      kind_q[head] == K_ST:  is_st  = 1'b1;
      kind_q[head] == K_BR:  is_chk = 1'b1;
      kind_q[head] == K_JMP: begin
        is_reg    = 1'b1;
        is_chk    = 1'b1;
        eff_taken = 1'b1;
      end
      default: ;
    endcase
  end

  assign mispred  = is_chk && (eff_taken != pred_q[head]);
  assign redir_pc = eff_taken ? tgt_q[head]
                              : pc_q[head] + ADDR_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      ready_q <= '0;
      c_reg   <= 1'b0;
      c_store <= 1'b0;
      c_redir <= 1'b0;
      c_flush <= 1'b0;
      c_rd    <= '0;
      c_tag   <= '0;
      c_val   <= '0;
      c_pc    <= '0;
    end else if (rdy) begin
      c_reg   <= 1'b0;
      c_store <= 1'b0;
      c_redir <= 1'b0;
      c_flush <= 1'b0;
      c_rd    <= '0;
      c_tag   <= '0;
      c_val   <= '0;
      c_pc    <= '0;
      if (c_flush) begin
        head    <= '0;
        tail    <= '0;
        cnt     <= '0;
        ready_q <= '0;
      end else begin
        if (do_commit) begin
          head          <= head + IDX_W'(1);
          ready_q[head] <= 1'b0;
          c_reg         <= is_reg;
          c_store       <= is_st;
          c_redir       <= mispred;
          c_flush       <= mispred;
          c_rd          <= rd_q[head];
          c_tag         <= head;
          c_val         <= val_q[head];
          c_pc          <= mispred ? redir_pc : '0;
        end
        if (accept) begin
          tail          <= tail + IDX_W'(1);
          ready_q[tail] <= io.disp_kind == K_ST;
        end
        if (wb0_ok) ready_q[io.wb0_tag] <= 1'b1;
        if (wb1_ok) ready_q[io.wb1_tag] <= 1'b1;
        cnt <= cnt + {{IDX_W{1'b0}}, accept}
                   - {{IDX_W{1'b0}}, do_commit};
      end
    end
  end

  // Payload needs no reset: ready_q gates every use.
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_q[tail] <= io.disp_kind;
      rd_q[tail]   <= io.disp_rd;
      pc_q[tail]   <= io.disp_pc;
      pred_q[tail] <= io.disp_pred_taken;
      val_q[tail]  <= '0;
      tkn_q[tail]  <= 1'b0;
      tgt_q[tail]  <= '0;
    end
    if (wb0_ok) begin
      val_q[io.wb0_tag] <= io.wb0_value;
      tkn_q[io.wb0_tag] <= io.wb0_taken;
      tgt_q[io.wb0_tag] <= io.wb0_target;
    end
    if (wb1_ok) val_q[io.wb1_tag] <= io.wb1_value;
  end

  always_comb begin
    io.q1_ready = ready_q[io.q1_tag];
    io.q1_value = val_q[io.q1_tag];
    if (io.wb0_valid && io.wb0_tag == io.q1_tag) begin
      io.q1_ready = 1'b1;
      io.q1_value = io.wb0_value;
    end
    if (io.wb1_valid && io.wb1_tag == io.q1_tag) begin
      io.q1_ready = 1'b1;
      io.q1_value = io.wb1_value;
    end
  end

  always_comb begin
    io.q2_ready = ready_q[io.q2_tag];
    io.q2_value = val_q[io.q2_tag];
    if (io.wb0_valid && io.wb0_tag == io.q2_tag) begin
      io.q2_ready = 1'b1;
      io.q2_value = io.wb0_value;
    end
    if (io.wb1_valid && io.wb1_tag == io.q2_tag) begin
      io.q2_ready = 1'b1;
      io.q2_value = io.wb1_value;
    end
  end

  // Pulses stay latched across a stall but are hidden while rdy is low.
  assign io.alloc_tag          = tail;
  assign io.full               = full;
  assign io.count              = cnt;
  assign io.commit_reg_valid   = c_reg & rdy;
  assign io.commit_store_valid = c_store & rdy;
  assign io.redirect_valid     = c_redir & rdy;
  assign io.flush              = c_flush & rdy;
  assign io.commit_rd          = c_rd;
  assign io.commit_tag         = c_tag;
  assign io.commit_value       = c_val;
  assign io.redirect_pc        = c_pc;
endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios
// plus random traffic against a queue-based ROB model.
module tb_rob_param;
  localparam int DEPTH = 16;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
    logic        ready;
    int          tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int checks = 0;
  int errors = 0;

  ent_t mq[$];
  int mtail;
  logic exp_reg, exp_store, exp_redir, exp_flush;
  logic [4:0] exp_rd;
  logic [3:0] exp_tag;
  logic [31:0] exp_val, exp_pc;

  rob_if bus ();

  rob_param dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .io  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle;
    bus.disp_valid = 0; bus.disp_kind = 0;
    bus.disp_rd = 0; bus.disp_pc = 0;
    bus.disp_pred_taken = 0;
    bus.q1_tag = 0; bus.q2_tag = 0;
    bus.wb0_valid = 0; bus.wb0_tag = 0;
    bus.wb0_value = 0; bus.wb0_taken = 0;
    bus.wb0_target = 0;
    bus.wb1_valid = 0; bus.wb1_tag = 0;
    bus.wb1_value = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle;
    rdy = 1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic disp(input logic [1:0] k,
                      input logic [4:0] rd,
                      input logic [31:0] pc,
                      input logic pr);
    bus.disp_valid = 1; bus.disp_kind = k;
    bus.disp_rd = rd; bus.disp_pc = pc;
    bus.disp_pred_taken = pr;
    tick;
    bus.disp_valid = 0;
  endtask

  task automatic test_reset;
    idle;
    rst = 1;
    #2;
    checks++;
    if (bus.count !== 5'd0) begin
      errors++; $display("FAIL rst_count got %0d exp 0", bus.count);
    end
    checks++;
    if (bus.full !== 1'b0) begin
      errors++; $display("FAIL rst_full got %b exp 0", bus.full);
    end
    checks++;
    if (bus.alloc_tag !== 4'd0) begin
      errors++; $display("FAIL rst_alloc got %0d exp 0", bus.alloc_tag);
    end
    checks++;
    if ({bus.commit_reg_valid, bus.commit_store_valid,
         bus.redirect_valid, bus.flush} !== 4'b0) begin
      errors++; $display("FAIL rst_pulses got nonzero exp 0");
    end
    do_reset;
  endtask

  task automatic test_fill;
    do_reset;
    for (int i = 0; i < DEPTH; i++) disp(2'd0, 5'(i), 32'(i * 4), 0);
    checks++;
    if (bus.full !== 1'b1) begin
      errors++; $display("FAIL fill_full got %b exp 1", bus.full);
    end
    checks++;
    if (bus.count !== 5'd16) begin
      errors++; $display("FAIL fill_count got %0d exp 16", bus.count);
    end
    disp(2'd0, 5'd1, 32'h40, 0);
    checks++;
    if (bus.count !== 5'd16) begin
      errors++; $display("FAIL over_count got %0d exp 16", bus.count);
    end
    checks++;
    if (bus.alloc_tag !== 4'd0) begin
      errors++; $display("FAIL over_alloc got %0d exp 0", bus.alloc_tag);
    end
  endtask

  task automatic test_ooo_commit;
    logic [3:0] tags[$];
    logic [31:0] vals[$];
    logic [4:0] rds[$];
    logic [3:0] et[3];
    logic [31:0] ev[3];
    logic [4:0] er[3];
    et = '{4'd0, 4'd1, 4'd2};
    ev = '{32'h10, 32'h20, 32'h30};
    er = '{5'd5, 5'd6, 5'd7};
    do_reset;
    disp(2'd0, 5'd5, 32'h0, 0);
    disp(2'd0, 5'd6, 32'h4, 0);
    disp(2'd0, 5'd7, 32'h8, 0);
    for (int c = 0; c < 10; c++) begin
      idle;
      if (c == 0) begin
        bus.wb0_valid = 1; bus.wb0_tag = 2; bus.wb0_value = 32'h30;
      end else if (c == 1) begin
        bus.wb1_valid = 1; bus.wb1_tag = 0; bus.wb1_value = 32'h10;
      end else if (c == 2) begin
        bus.wb0_valid = 1; bus.wb0_tag = 1; bus.wb0_value = 32'h20;
      end
      tick;
      if (bus.commit_reg_valid === 1'b1) begin
        tags.push_back(bus.commit_tag);
        vals.push_back(bus.commit_value);
        rds.push_back(bus.commit_rd);
      end
    end
    idle;
    checks++;
    if (tags.size() != 3) begin
      errors++; $display("FAIL ooo_ncommit got %0d exp 3", tags.size());
    end
    for (int i = 0; i < 3 && i < tags.size(); i++) begin
      checks++;
      if (tags[i] !== et[i] || vals[i] !== ev[i] || rds[i] !== er[i]) begin
        errors++;
        $display("FAIL ooo_commit%0d got tag %0d val %h rd %0d exp %0d %h %0d",
                 i, tags[i], vals[i], rds[i], et[i], ev[i], er[i]);
      end
    end
  endtask

  task automatic test_bypass;
    do_reset;
    for (int i = 0; i < 4; i++) disp(2'd0, 5'(i + 1), 32'(i * 4), 0);
    bus.q1_tag = 3; bus.q2_tag = 1;
    bus.wb1_valid = 1; bus.wb1_tag = 3; bus.wb1_value = 32'hABCD;
    bus.wb0_valid = 1; bus.wb0_tag = 3; bus.wb0_value = 32'h1111;
    #1;
    checks++;
    if (bus.q1_ready !== 1'b1 || bus.q1_value !== 32'hABCD) begin
      errors++; $display("FAIL bypass got %b %h exp 1 abcd", bus.q1_ready, bus.q1_value);
    end
    checks++;
    if (bus.q2_ready !== 1'b0) begin
      errors++; $display("FAIL lookup_notready got %b exp 0", bus.q2_ready);
    end
    tick;
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    #1;
    checks++;
    if (bus.q1_ready !== 1'b1 || bus.q1_value !== 32'hABCD) begin
      errors++; $display("FAIL wb1_wins got %b %h exp 1 abcd", bus.q1_ready, bus.q1_value);
    end
    idle;
  endtask

  task automatic test_branch_ok;
    do_reset;
    disp(2'd1, 5'd0, 32'h100, 1);
    bus.wb0_valid = 1; bus.wb0_tag = 0;
    bus.wb0_taken = 1; bus.wb0_target = 32'h500;
    tick;
    idle;
    checks++;
    if (bus.count !== 5'd1) begin
      errors++; $display("FAIL br_count_pre got %0d exp 1", bus.count);
    end
    tick;
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL br_ok_flush got %b %b exp 0 0", bus.redirect_valid, bus.flush);
    end
    checks++;
    if (bus.count !== 5'd0 || bus.commit_reg_valid !== 1'b0) begin
      errors++; $display("FAIL br_ok_commit got cnt %0d reg %b exp 0 0", bus.count, bus.commit_reg_valid);
    end
  endtask

  task automatic test_mispredict;
    do_reset;
    disp(2'd1, 5'd0, 32'h200, 1);
    disp(2'd0, 5'd3, 32'h204, 0);
    bus.wb0_valid = 1; bus.wb0_tag = 0; bus.wb0_taken = 0;
    bus.wb0_target = 32'h900;
    tick;
    idle;
    tick;
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.flush !== 1'b1) begin
      errors++; $display("FAIL mp_pulse got %b %b exp 1 1", bus.redirect_valid, bus.flush);
    end
    checks++;
    if (bus.redirect_pc !== 32'h204) begin
      errors++; $display("FAIL mp_pc got %h exp 204", bus.redirect_pc);
    end
    bus.wb1_valid = 1; bus.wb1_tag = 1; bus.wb1_value = 32'h99;
    bus.disp_valid = 1; bus.disp_kind = 0;
    tick;
    idle;
    checks++;
    if (bus.count !== 5'd0 || bus.alloc_tag !== 4'd0) begin
      errors++; $display("FAIL mp_clear got cnt %0d tag %0d exp 0 0", bus.count, bus.alloc_tag);
    end
    checks++;
    if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      errors++; $display("FAIL mp_pulse_end got %b %b exp 0 0", bus.flush, bus.redirect_valid);
    end
    bus.q1_tag = 1;
    #1;
    checks++;
    if (bus.q1_ready !== 1'b0) begin
      errors++; $display("FAIL mp_wb_ignored got %b exp 0", bus.q1_ready);
    end
    disp(2'd3, 5'd9, 32'h300, 0);
    bus.wb0_valid = 1; bus.wb0_tag = 0; bus.wb0_value = 32'h304;
    bus.wb0_taken = 0; bus.wb0_target = 32'h800;
    tick;
    idle;
    tick;
    checks++;
    if (bus.commit_reg_valid !== 1'b1 || bus.commit_rd !== 5'd9 ||
        bus.commit_value !== 32'h304) begin
      errors++; $display("FAIL jmp_commit got %b %0d %h exp 1 9 304",
                         bus.commit_reg_valid, bus.commit_rd, bus.commit_value);
    end
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h800) begin
      errors++; $display("FAIL jmp_redirect got %b %h exp 1 800", bus.redirect_valid, bus.redirect_pc);
    end
    tick;
  endtask

  task automatic test_wrap;
    do_reset;
    for (int i = 0; i < 12; i++) disp(2'd0, 5'(i), 32'(i * 4), 0);
    for (int k = 0; k < 20; k++) begin
      idle;
      bus.disp_valid = 1; bus.disp_kind = 0; bus.disp_rd = 5'(k);
      bus.wb0_valid = 1; bus.wb0_tag = 4'(k % 16); bus.wb0_value = 32'(k);
      tick;
      checks++;
      if (bus.count !== 5'd13 || bus.alloc_tag !== 4'((13 + k) % 16)) begin
        errors++; $display("FAIL wrap_cnt k%0d got %0d tag %0d exp 13 %0d",
                           k, bus.count, bus.alloc_tag, (13 + k) % 16);
      end
      if (k > 0) begin
        checks++;
        if (bus.commit_reg_valid !== 1'b1 || bus.commit_tag !== 4'((k - 1) % 16) ||
            bus.commit_value !== 32'(k - 1)) begin
          errors++; $display("FAIL wrap_commit k%0d got %b %0d %0d exp 1 %0d %0d",
                             k, bus.commit_reg_valid, bus.commit_tag,
                             bus.commit_value, (k - 1) % 16, k - 1);
        end
      end
    end
    idle;
  endtask

  task automatic test_rst_mid;
    rst = 1;
    #1;
    checks++;
    if (bus.commit_reg_valid !== 1'b0 || bus.commit_value !== 32'd0 ||
        bus.commit_tag !== 4'd0 || bus.count !== 5'd0) begin
      errors++; $display("FAIL rst_mid got %b %h %0d %0d exp all 0",
                         bus.commit_reg_valid, bus.commit_value,
                         bus.commit_tag, bus.count);
    end
    do_reset;
  endtask

  task automatic test_rdy;
    do_reset;
    disp(2'd0, 5'd1, 32'h0, 0);
    disp(2'd0, 5'd2, 32'h4, 0);
    rdy = 0;
    bus.disp_valid = 1;
    bus.wb0_valid = 1; bus.wb0_tag = 0; bus.wb0_value = 32'h55;
    tick;
    idle;
    #1;
    checks++;
    if (bus.count !== 5'd2 || bus.q1_ready !== 1'b0) begin
      errors++; $display("FAIL rdy_hold got cnt %0d rdy %b exp 2 0", bus.count, bus.q1_ready);
    end
    rdy = 1;
    bus.wb0_valid = 1; bus.wb0_tag = 0; bus.wb0_value = 32'h55;
    tick;
    idle;
    tick;
    checks++;
    if (bus.commit_reg_valid !== 1'b1 || bus.commit_value !== 32'h55) begin
      errors++; $display("FAIL rdy_commit got %b %h exp 1 55", bus.commit_reg_valid, bus.commit_value);
    end
    rdy = 0;
    #1;
    checks++;
    if (bus.commit_reg_valid !== 1'b0) begin
      errors++; $display("FAIL rdy_mask got %b exp 0", bus.commit_reg_valid);
    end
    rdy = 1;
    do_reset;
  endtask

  task automatic model_edge;
    ent_t e;
    logic tk;
    int n0;
    if (exp_flush) begin
      mq.delete();
      mtail = 0;
      {exp_reg, exp_store, exp_redir, exp_flush} = 4'b0;
      return;
    end
    n0 = mq.size();
    {exp_reg, exp_store, exp_redir, exp_flush} = 4'b0;
    if (n0 > 0 && mq[0].ready) begin
      e = mq.pop_front();
      tk = (e.kind == 3) ? 1'b1 : e.taken;
      exp_reg = (e.kind == 0 || e.kind == 3);
      exp_store = (e.kind == 2);
      exp_rd = e.rd;
      exp_tag = 4'(e.tag);
      exp_val = e.value;
      if ((e.kind == 1 || e.kind == 3) && tk != e.pred) begin
        exp_redir = 1;
        exp_flush = 1;
        exp_pc = tk ? e.target : e.pc + 32'd4;
      end
    end
    if (bus.disp_valid && n0 < DEPTH) begin
      e.kind = bus.disp_kind; e.rd = bus.disp_rd;
      e.pc = bus.disp_pc; e.pred = bus.disp_pred_taken;
      e.value = 0; e.taken = 0; e.target = 0;
      e.ready = (bus.disp_kind == 2); e.tag = mtail;
      mq.push_back(e);
      mtail = (mtail + 1) % DEPTH;
    end
    foreach (mq[i]) begin
      if (bus.wb0_valid && mq[i].tag == int'(bus.wb0_tag)) begin
        mq[i].ready = 1; mq[i].value = bus.wb0_value;
        mq[i].taken = bus.wb0_taken; mq[i].target = bus.wb0_target;
      end
      if (bus.wb1_valid && mq[i].tag == int'(bus.wb1_tag)) begin
        mq[i].ready = 1; mq[i].value = bus.wb1_value;
      end
    end
  endtask

  task automatic test_random;
    int pend[$];
    int r, qi;
    logic er;
    logic [31:0] ev;
    do_reset;
    mq.delete();
    mtail = 0;
    {exp_reg, exp_store, exp_redir, exp_flush} = 4'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle;
      bus.disp_valid = ($urandom_range(0, 99) < 55);
      r = $urandom_range(0, 99);
      bus.disp_kind = r < 55 ? 2'd0 : r < 70 ? 2'd2 : r < 85 ? 2'd1 : 2'd3;
      bus.disp_rd = 5'($urandom);
      bus.disp_pc = 32'($urandom) & 32'hFFFF_FFFC;
      bus.disp_pred_taken = 1'($urandom);
      pend.delete();
      foreach (mq[i]) if (!mq[i].ready) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(0, 99) < 60) begin
        bus.wb0_valid = 1;
        bus.wb0_tag = 4'(mq[pend[$urandom_range(0, pend.size() - 1)]].tag);
        bus.wb0_value = $urandom; bus.wb0_taken = 1'($urandom);
        bus.wb0_target = $urandom;
      end
      if (pend.size() > 0 && $urandom_range(0, 99) < 50) begin
        bus.wb1_valid = 1;
        bus.wb1_tag = 4'(mq[pend[$urandom_range(0, pend.size() - 1)]].tag);
        bus.wb1_value = $urandom;
      end
      qi = -1;
      if (mq.size() > 0) begin
        qi = $urandom_range(0, mq.size() - 1);
        bus.q1_tag = 4'(mq[qi].tag);
      end
      #1;
      checks++;
      if (bus.count !== 5'(mq.size()) || bus.alloc_tag !== 4'(mtail) ||
          bus.full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_occ c%0d got %0d %0d %b exp %0d %0d",
                           cyc, bus.count, bus.alloc_tag, bus.full, mq.size(), mtail);
      end
      checks++;
      if ({bus.commit_reg_valid, bus.commit_store_valid, bus.redirect_valid, bus.flush} !==
          {exp_reg, exp_store, exp_redir, exp_flush}) begin
        errors++; $display("FAIL rnd_pulse c%0d got %b%b%b%b exp %b%b%b%b", cyc,
                           bus.commit_reg_valid, bus.commit_store_valid,
                           bus.redirect_valid, bus.flush,
                           exp_reg, exp_store, exp_redir, exp_flush);
      end
      if (exp_reg || exp_store) begin
        checks++;
        if (bus.commit_tag !== exp_tag) begin
          errors++; $display("FAIL rnd_tag c%0d got %0d exp %0d", cyc, bus.commit_tag, exp_tag);
        end
      end
      if (exp_reg) begin
        checks++;
        if (bus.commit_rd !== exp_rd || bus.commit_value !== exp_val) begin
          errors++; $display("FAIL rnd_reg c%0d got %0d %h exp %0d %h",
                             cyc, bus.commit_rd, bus.commit_value, exp_rd, exp_val);
        end
      end
      if (exp_redir) begin
        checks++;
        if (bus.redirect_pc !== exp_pc) begin
          errors++; $display("FAIL rnd_rpc c%0d got %h exp %h", cyc, bus.redirect_pc, exp_pc);
        end
      end
      if (qi >= 0) begin
        er = mq[qi].ready;
        ev = mq[qi].value;
        if (bus.wb0_valid && bus.wb0_tag == bus.q1_tag) begin
          er = 1; ev = bus.wb0_value;
        end
        if (bus.wb1_valid && bus.wb1_tag == bus.q1_tag) begin
          er = 1; ev = bus.wb1_value;
        end
        checks++;
        if (bus.q1_ready !== er ||
            (er && mq[qi].kind != 2 && bus.q1_value !== ev)) begin
          errors++; $display("FAIL rnd_lookup c%0d got %b %h exp %b %h",
                             cyc, bus.q1_ready, bus.q1_value, er, ev);
        end
      end
      model_edge;
      @(posedge clk);
      #1;
    end
    idle;
  endtask

  initial begin
    idle;
    test_reset;
    test_fill;
    test_ooo_commit;
    test_bypass;
    test_branch_ok;
    test_mispredict;
    test_wrap;
    test_rst_mid;
    test_rdy;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
